// File: rtl/mac_writeback.sv
// rtl/mac_writeback.sv - MAC result collector: tag pipe, result FIFO, memory write port, issue stall
//
// Ports:
//   clk, arst_n_in      clock (rising edge), asynchronous active-low reset
//   clear               synchronous flush of tags, FIFO, write counter and error flag
//   mac_advance         MAC pipeline enable for this cycle
//   mac_last_in         operand set issued this cycle closes its accumulation
//   mac_out, mac_ch_out MAC result and channel tag at the pipeline output
//   stall_out           issuer must not advance while high
//   mem_we, mem_addr, mem_wdata, mem_ready   valid/ready write port (FIFO head)
//   written_count       completed writes, wraps at 2^16
//   overflow_err        sticky: a result arrived while the FIFO was full
module mac_writeback #(
    parameter int OUTPUT_WIDTH = 16,
    parameter int CH_WIDTH     = 32,
    parameter int LATENCY      = 4,
    parameter int FIFO_DEPTH   = 4,
    parameter int ADDR_WIDTH   = 16
) (
    input  logic                    clk,
    input  logic                    arst_n_in,
    input  logic                    clear,
    input  logic                    mac_advance,
    input  logic                    mac_last_in,
    input  logic [OUTPUT_WIDTH-1:0] mac_out,
    input  logic [CH_WIDTH-1:0]     mac_ch_out,
    output logic                    stall_out,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [OUTPUT_WIDTH-1:0] mem_wdata,
    input  logic                    mem_ready,
    output logic [15:0]             written_count,
    output logic                    overflow_err
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SUM_W = $clog2(FIFO_DEPTH + LATENCY + 1) + 1;

    logic [LATENCY-1:0]    tag;
    logic                  fresh;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic [ADDR_WIDTH-1:0] addr_mem [FIFO_DEPTH];
    logic [OUTPUT_WIDTH-1:0] data_mem [FIFO_DEPTH];

    logic                  capture;
    logic                  full;
    logic                  pop;
    logic                  push;
    logic                  drop;
    logic [SUM_W-1:0]      outstanding;

    // Only the address bits of the channel tag are stored.
    generate
        if (CH_WIDTH > ADDR_WIDTH) begin : g_unused_ch
            logic unused_ch;
            assign unused_ch = ^mac_ch_out[CH_WIDTH-1:ADDR_WIDTH];
        end
    endgenerate

    // A result sitting in the last tag stage is only valid in the cycle right
    // after the advance that moved it there; fresh qualifies that, so an idle
    // MAC never re-captures the same result.
    assign capture = fresh & tag[LATENCY-1];
    assign full    = (count == CNT_W'(FIFO_DEPTH));
    assign mem_we  = (count != '0);
    assign pop     = mem_we & mem_ready;
    assign push    = capture & (~full | pop);
    assign drop    = capture & full & ~pop;

    assign mem_addr  = addr_mem[rd_ptr];
    assign mem_wdata = data_mem[rd_ptr];

    // Results still inside the MAC (including one about to be captured) each
    // reserve a FIFO slot, so the stall never lets a finished result be lost.
    always_comb begin
        outstanding = SUM_W'(capture);
        for (int i = 0; i < LATENCY - 1; i++) begin
            outstanding = outstanding + SUM_W'(tag[i]);
        end
    end

    assign stall_out = (SUM_W'(count) + outstanding) >= SUM_W'(FIFO_DEPTH);

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            tag   <= '0;
            fresh <= 1'b0;
        end else if (clear) begin
            tag   <= '0;
            fresh <= 1'b0;
        end else begin
            fresh <= mac_advance;
            if (mac_advance) begin
                tag <= {tag[LATENCY-2:0], mac_last_in};
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            written_count <= '0;
            overflow_err  <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                addr_mem[i] <= '0;
                data_mem[i] <= '0;
            end
        end else if (clear) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            written_count <= '0;
            overflow_err  <= 1'b0;
        end else begin
            if (push) begin
                addr_mem[wr_ptr] <= mac_ch_out[ADDR_WIDTH-1:0];
                data_mem[wr_ptr] <= mac_out;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr        <= rd_ptr + 1'b1;
                written_count <= written_count + 16'd1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            if (drop) begin
                overflow_err <= 1'b1;
            end
        end
    end

endmodule

// File: doc/mac_writeback.md
# mac_writeback

Result collector on the output side of the 3-tap pipelined MAC processing element. Tracks which issued operand sets close an accumulation, captures the finished accumulator value and its channel tag when they emerge from the MAC pipeline, buffers them in a small FIFO, and drains them to output memory over a valid/ready write port. It also generates the stall that the operand issuer must honour so that no finished result can be lost.

## Interface
Parameters:
- OUTPUT_WIDTH, 16: width of the MAC `out` result.
- CH_WIDTH, 32: width of the channel tag travelling with each result.
- LATENCY, 4: number of enabled cycles through the MAC pipeline (≥2).
- FIFO_DEPTH, 4: result FIFO entries (≥2, power of two).
- ADDR_WIDTH, 16: memory address width (≤ CH_WIDTH).

Ports:
- clk  in  1  clock, rising edge.
- arst_n_in  in  1  asynchronous reset, active low.
- clear  in  1  synchronous flush of tags, FIFO, counter, error flag.
- mac_advance  in  1  the same enable driven onto the MAC `input_valid` this cycle.
- mac_last_in  in  1  operand set issued this cycle is the final term of its accumulation.
- mac_out  in  OUTPUT_WIDTH  MAC result output.
- mac_ch_out  in  CH_WIDTH  MAC channel tag output.
- stall_out  out  1  issuer must hold `mac_advance` low while high.
- mem_we  out  1  write request valid.
- mem_addr  out  ADDR_WIDTH  write address = `mac_ch_out[ADDR_WIDTH-1:0]` of the entry.
- mem_wdata  out  OUTPUT_WIDTH  write data.
- mem_ready  in  1  memory accepts the write this cycle.
- written_count  out  16  number of completed writes, wraps at 2^16.
- overflow_err  out  1  sticky: push attempted into a full FIFO.

## Operation
- Tag pipe `tag[LATENCY-1:0]`: on `mac_advance`, `tag[0]` ← `mac_last_in` and `tag[i]` ← `tag[i-1]`; otherwise it holds. Mirrors the MAC stage enables exactly.
- `fresh` register ← `mac_advance` every cycle.
- Capture condition: `fresh & tag[LATENCY-1]`. On capture, push {`mac_ch_out`, `mac_out`} into the FIFO. A tag that stays at the last stage while the MAC is idle is never captured twice.
- Outstanding = popcount(`tag[LATENCY-2:0]`) + (`tag[LATENCY-1] & fresh`).
- `stall_out` = (fifo_count + outstanding ≥ FIFO_DEPTH). This is combinational from registers only and does not depend on `mac_last_in`.
- Invariant: fifo_count + outstanding ≤ FIFO_DEPTH whenever the issuer honours `stall_out`.
- FIFO is first-word-fall-through. `mem_we` = !empty. `mem_addr` and `mem_wdata` come from the head entry.
- Pop when `mem_we & mem_ready`; on pop, `written_count` increments.
- Push and pop in the same cycle: both happen and the count is unchanged. This is legal when full.
- Push while full with no pop: the entry is dropped, FIFO contents are unchanged, and `overflow_err` is set (sticky).
- `clear`: tag pipe, `fresh`, FIFO pointers and count, `written_count` and `overflow_err` all go to 0 at the edge. `clear` has priority over push, pop and advance in the same cycle.
- Pointers wrap modulo FIFO_DEPTH.

## Timing
- Reset (asynchronous, `arst_n_in` low): `tag` = 0, `fresh` = 0, FIFO empty, storage = 0.
  - Outputs during and after reset: `stall_out` = 0, `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0, `written_count` = 0, `overflow_err` = 0.
  - Reset mid-drain discards all pending results.
- Capture latency: the final operand set is advanced in cycle t. The MAC needs three further advances, in any later cycles. The capture edge is at the end of the cycle following the LATENCY-th advance. `mem_we` rises the next cycle.
  - With back-to-back advances t..t+3, `mem_we` is high in cycle t+5.
- Handshake: `mem_addr` and `mem_wdata` must hold stable while `mem_we & !mem_ready`. `mem_we` never drops without an accepted transfer, except on `clear` or reset.
- Throughput: one write per cycle when `mem_ready` is held high.
- `stall_out` reflects state at the start of the cycle. The issuer samples it in the same cycle it decides `mac_advance`.

## Test plan
- **Single accumulation:** advance 4 cycles with `mac_last_in` = 1, 0, 0, 0; drive `mac_out` = 0x1234, `mac_ch_out` = 7; hold `mem_ready` = 1.
  - Required: exactly one write (addr 7, data 0x1234) in cycle 5; `written_count` = 1.
- **Idle MAC after result:** stop advancing after the result reaches the last stage; hold 10 idle cycles.
  - Required: exactly one push and one write; no duplicate.
- **Back-pressure:** `mem_ready` = 0; issue 8 accumulations, each with `mac_last_in` = 1.
  - Required: `stall_out` rises once fifo_count + outstanding = 4; FIFO holds 4 entries; `overflow_err` stays 0.
  - Then release `mem_ready`: 4 writes in issue order, stall drops, and the remaining 4 follow. Total `written_count` = 8.
- **Stable under wait:** `mem_ready` toggles 0,0,1.
  - Required: addr and data are unchanged across the wait cycles.
- **Forced overflow:** ignore `stall_out` with `mem_ready` = 0 and push 5 results.
  - Required: `overflow_err` = 1 and stays 1; the first 4 entries drain intact.
- **Clear and reset mid-operation:** assert `clear` with 3 entries queued and 2 outstanding.
  - Required next cycle: `mem_we` = 0, `stall_out` = 0, `written_count` = 0, `overflow_err` = 0.
  - Repeat with asynchronous `arst_n_in` pulsed low mid-cycle: identical result immediately.
